// File: rtl/k_and_s_pkg.sv
// Shared types and sizing constants for the K&S processor memory responder.
package k_and_s_pkg;

    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 16;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/ks_mem_responder_if.sv
// Processor request/acknowledge bus plus the program-loader write port.
interface ks_mem_responder_if;
    import k_and_s_pkg::*;

    logic  ram_req;
    logic  ram_we;
    addr_t ram_addr;
    data_t ram_wdata;
    data_t ram_rdata;
    logic  ram_ack;
    logic  ld_valid;
    addr_t ld_addr;
    data_t ld_data;
    logic  ld_ready;

    modport master (
        output ram_req, ram_we, ram_addr, ram_wdata, ld_valid, ld_addr, ld_data,
        input  ram_rdata, ram_ack, ld_ready
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_wdata, ld_valid, ld_addr, ld_data,
        output ram_rdata, ram_ack, ld_ready
    );

endinterface

// File: rtl/ks_mem_array.sv
// 32 x 16 storage with one synchronous write port and one registered read port.
module ks_mem_array
    import k_and_s_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata,
    input  logic  re,
    input  addr_t raddr,
    output data_t rdata
);

    data_t mem_r [MEM_DEPTH];
    data_t rdata_r;

    // storage words, all cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // read register only moves on a read strobe, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/ks_mem_responder.sv
// Memory responder: serialises processor accesses with programmable wait states
// and lets the program loader write only when the processor is not asking.
module ks_mem_responder
    import k_and_s_pkg::*;
#(
    parameter int WAIT_STATES = 1
)
(
    input  logic              clk,
    input  logic              rst,
    ks_mem_responder_if.slave bus
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);
    localparam logic             NO_WAIT   = (WAIT_STATES == 0);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ack_r;
    logic             cap_we_r;
    addr_t            cap_addr_r;
    data_t            cap_wdata_r;

    logic  go_resp_s;
    logic  cmt_we_s;
    addr_t cmt_addr_s;
    data_t cmt_wdata_s;
    logic  ld_ready_s;
    logic  mem_we_s;
    logic  mem_re_s;
    addr_t mem_waddr_s;
    data_t mem_wdata_s;
    data_t rdata_s;

    // with no wait states the commit uses the live bus, otherwise the captured copy
    always_comb begin
        go_resp_s   = 1'b0;
        cmt_we_s    = cap_we_r;
        cmt_addr_s  = cap_addr_r;
        cmt_wdata_s = cap_wdata_r;
        case (state_r)
            IDLE: begin
                go_resp_s   = bus.ram_req && NO_WAIT;
                cmt_we_s    = bus.ram_we;
                cmt_addr_s  = bus.ram_addr;
                cmt_wdata_s = bus.ram_wdata;
            end
            WAIT:    go_resp_s = (cnt_r == 3'd1);
            RESP:    go_resp_s = 1'b0;
            default: go_resp_s = 1'b0;
        endcase
    end

    assign ld_ready_s = (state_r == IDLE) && !bus.ram_req && !rst;

    // single write port shared by processor commit and loader (never both at once)
    always_comb begin
        mem_re_s = go_resp_s && !cmt_we_s;
        if (go_resp_s) begin
            mem_we_s    = cmt_we_s;
            mem_waddr_s = cmt_addr_s;
            mem_wdata_s = cmt_wdata_s;
        end else begin
            mem_we_s    = ld_ready_s && bus.ld_valid;
            mem_waddr_s = bus.ld_addr;
            mem_wdata_s = bus.ld_data;
        end
    end

    // request FSM: capture, wait-state countdown, one-cycle acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            ack_r       <= 1'b0;
            cap_we_r    <= 1'b0;
            cap_addr_r  <= {ADDR_W{1'b0}};
            cap_wdata_r <= {DATA_W{1'b0}};
        end else begin
            ack_r <= go_resp_s;
            case (state_r)
                IDLE: begin
                    if (bus.ram_req) begin
                        cap_we_r    <= bus.ram_we;
                        cap_addr_r  <= bus.ram_addr;
                        cap_wdata_r <= bus.ram_wdata;
                        cnt_r       <= WAIT_INIT;
                        state_r     <= NO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - 3'd1;
                    if (go_resp_s) begin
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    ks_mem_array u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we_s),
        .waddr (mem_waddr_s),
        .wdata (mem_wdata_s),
        .re    (mem_re_s),
        .raddr (cmt_addr_s),
        .rdata (rdata_s)
    );

    assign bus.ram_ack   = ack_r;
    assign bus.ram_rdata = rdata_s;
    assign bus.ld_ready  = ld_ready_s;

endmodule
